nn_avalon_slave: RTL and testbench
==================================

// Module: nn_avalon_slave
// PURPOSE
//  Avalon-MM slave front end of the neural-network accelerator. Decodes host reads and writes
//  (single and fixed-address burst) and streams pixel and weight data into the on-chip memories
//  through auto-incrementing pointers. Exposes control/status and result registers and issues
//  start_calc to the main controller.
// PARAMETERS
//  NUM_RESULTS  10   result registers readable at 0x010..0x019 (output_address range)
// PORTS
//  clk                 in   1   system clock, rising edge
//  n_rst               in   1   asynchronous active-low reset
//  read                in   1   Avalon read request
//  write               in   1   Avalon write request
//  beginbursttransfer  in   1   first-beat marker of a burst
//  burstcount          in   10  beats in burst, sampled with beginbursttransfer
//  address             in   11  word address
//  writedata           in   32  write data
//  readdata            out  32  read data, valid with readdatavalid
//  readdatavalid       out  1   one-cycle read-data strobe
//  waitrequest         out  1   high = slave not accepting; low for exactly one cycle per accepted beat
//  response            out  2   00 OKAY, 10 SLVERR (unmapped address or illegal access)
//  result_output       in   17  result selected by output_address, from result memory
//  done_calc           in   1   one-cycle pulse from main controller: calculation finished
//  start_calc          out  1   one-cycle pulse: begin calculation
//  output_address      out  4   result index for reads of 0x010..0x019
//  pixel_address       out  11  pixel memory write address
//  weight_address      out  11  weight memory write address
//  w_enable_pixels     out  1   pixel memory write enable, one cycle per stored word
//  w_enable_weights    out  1   weight memory write enable, one cycle per stored word
//  store_data          out  16  data for either memory = writedata[15:0]
// BEHAVIOUR
//  Reset: waitrequest=1; all other outputs, pointers, registers and counters = 0.
//  Address map:
//    0x000 CTRL   W: bit0=1 pulses start_calc (ignored while busy). R: {30'b0, busy, done}
//    0x001 SCRATCH 32-bit R/W
//    0x002 PIXDATA  W: store to pixel mem. R: SLVERR
//    0x003 WGTDATA  W: store to weight mem. R: SLVERR
//    0x004 PIXPTR   R/W, 11 bits, zero-extended on read
//    0x005 WGTPTR   R/W, 11 bits, zero-extended on read
//    0x010..0x019 RESULT  R: {15'b0, result_output}. W: SLVERR
//    Any other address: SLVERR, no side effect, readdata=0.
//  FSM IDLE/ACCEPT/RDATA. waitrequest=1 in IDLE and RDATA, 0 in ACCEPT.
//    IDLE: read or write sampled high -> ACCEPT. read has priority if both are high.
//    ACCEPT, write: register/memory update in this cycle; response set -> IDLE.
//    ACCEPT, read: output_address=address[3:0] -> RDATA.
//    RDATA: readdatavalid=1 and readdata driven for one cycle -> IDLE.
//    Read latency is 2 cycles from request sample to readdatavalid.
//  Memory store (ACCEPT, write to 0x002/0x003): w_enable_x=1, store_data=writedata[15:0],
//    x_address=pointer. Pointer increments by 1 after the store and wraps 2047->0.
//  Burst: beginbursttransfer with write latches burstcount (0 treated as 1) and address.
//    Each beat takes one IDLE->ACCEPT cycle pair, using the latched address (fixed-address burst).
//    After the last beat, return to single-transfer mode. A read burst returns one word per beat.
//  Status: done is set by a done_calc pulse and cleared by start_calc. busy is set by start_calc
//    and cleared by done_calc. A simultaneous start and done results in start winning.
//  response holds its last value until the next accepted transfer.
//  Asynchronous reset mid-transfer aborts the transfer and returns to IDLE immediately.
// TESTING
//  reset -> waitrequest=1, readdatavalid=0, start_calc=0, response=00
//  write 0x001=0x00000008, then read 0x001 -> one waitrequest-low cycle each;
//    readdatavalid 2 cycles after read, readdata=0x8, response=00
//  write PIXPTR=5, burst 10 to 0x002 with data 0,2,..,18 -> 10 w_enable_pixels pulses,
//    pixel_address 5..14, store_data 0..18; PIXPTR reads 15
//  write CTRL=1 -> single start_calc pulse; CTRL reads busy=1, done=0;
//    pulse done_calc -> CTRL reads 0x1
//  result_output=0x1ABCD, read 0x013 -> output_address=3, readdata=0x0001ABCD
//  read 0x002 or 0x7FF -> response=10, readdata=0; WGTPTR=2047 plus one write -> wraps to 0

Source files
------------

// File: rtl/nn_avalon_slave.sv
// Avalon-MM slave front end of the NN accelerator: register file, pixel/weight
// streaming through auto-incrementing pointers, result readback and start/done status.
module nn_avalon_slave #(
  parameter int NUM_RESULTS = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        read,
  input  logic        write,
  input  logic        beginbursttransfer,
  input  logic [9:0]  burstcount,
  input  logic [10:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic [1:0]  response,
  input  logic [16:0] result_output,
  input  logic        done_calc,
  output logic        start_calc,
  output logic [3:0]  output_address,
  output logic [10:0] pixel_address,
  output logic [10:0] weight_address,
  output logic        w_enable_pixels,
  output logic        w_enable_weights,
  output logic [15:0] store_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCEPT = 2'd1, RDATA = 2'd2} state_t;

  localparam logic [10:0] ADDR_CTRL      = 11'h000;
  localparam logic [10:0] ADDR_SCRATCH   = 11'h001;
  localparam logic [10:0] ADDR_PIXDATA   = 11'h002;
  localparam logic [10:0] ADDR_WGTDATA   = 11'h003;
  localparam logic [10:0] ADDR_PIXPTR    = 11'h004;
  localparam logic [10:0] ADDR_WGTPTR    = 11'h005;
  localparam logic [10:0] ADDR_RES_FIRST = 11'h010;
  localparam logic [10:0] ADDR_RES_LAST  = 11'(16 + NUM_RESULTS - 1);
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;

  state_t      state;
  logic [10:0] req_addr;
  logic [31:0] req_data;
  logic        req_read;
  logic [10:0] burst_addr;
  logic [9:0]  burst_left;
  logic [10:0] eff_addr;
  logic [10:0] pix_ptr;
  logic [10:0] wgt_ptr;
  logic [31:0] scratch;
  logic        busy;
  logic        done;
  logic [31:0] rd_value;
  logic        rd_err;
  logic        wr_err;
  logic        is_result;
  logic        start_req;

  // Remaining beats of a burst reuse the address latched on its first beat.
  assign eff_addr  = (burst_left != '0) ? burst_addr : address;
  assign is_result = (req_addr >= ADDR_RES_FIRST) && (req_addr <= ADDR_RES_LAST);
  assign wr_err    = !(req_addr inside {ADDR_CTRL, ADDR_SCRATCH, ADDR_PIXDATA,
                                        ADDR_WGTDATA, ADDR_PIXPTR, ADDR_WGTPTR});
  assign start_req = (state == ACCEPT) && !req_read && (req_addr == ADDR_CTRL) &&
                     req_data[0] && !busy;

  always_comb begin
    rd_value = '0;
    rd_err   = 1'b0;
    if (is_result) begin
      rd_value = {15'b0, result_output};
    end else begin
      case (req_addr)
        ADDR_CTRL:    rd_value = {30'b0, busy, done};
        ADDR_SCRATCH: rd_value = scratch;
        ADDR_PIXPTR:  rd_value = {21'b0, pix_ptr};
        ADDR_WGTPTR:  rd_value = {21'b0, wgt_ptr};
        default:      rd_err   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      waitrequest      <= 1'b1;
      readdata         <= '0;
      readdatavalid    <= 1'b0;
      response         <= RESP_OKAY;
      start_calc       <= 1'b0;
      output_address   <= '0;
      pixel_address    <= '0;
      weight_address   <= '0;
      w_enable_pixels  <= 1'b0;
      w_enable_weights <= 1'b0;
      store_data       <= '0;
      req_addr         <= '0;
      req_data         <= '0;
      req_read         <= 1'b0;
      burst_addr       <= '0;
      burst_left       <= '0;
      pix_ptr          <= '0;
      wgt_ptr          <= '0;
      scratch          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      readdatavalid    <= 1'b0;
      w_enable_pixels  <= 1'b0;
      w_enable_weights <= 1'b0;
      start_calc       <= 1'b0;

      // A start in the same cycle as done_calc takes precedence.
      if (start_req) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (done_calc) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (read || write) begin
            state       <= ACCEPT;
            waitrequest <= 1'b0;
            req_read    <= read;
            req_addr    <= eff_addr;
            req_data    <= writedata;
            if (burst_left != '0) begin
              burst_left <= burst_left - 10'd1;
            end else if (beginbursttransfer) begin
              burst_left <= (burstcount == '0) ? '0 : burstcount - 10'd1;
              burst_addr <= address;
            end
            if (read) begin
              output_address <= eff_addr[3:0];
            end else if (eff_addr == ADDR_PIXDATA) begin
              w_enable_pixels <= 1'b1;
              pixel_address   <= pix_ptr;
              store_data      <= writedata[15:0];
            end else if (eff_addr == ADDR_WGTDATA) begin
              w_enable_weights <= 1'b1;
              weight_address   <= wgt_ptr;
              store_data       <= writedata[15:0];
            end
          end
        end

        ACCEPT: begin
          waitrequest <= 1'b1;
          if (req_read) begin
            state         <= RDATA;
            readdatavalid <= 1'b1;
            readdata      <= rd_err ? '0 : rd_value;
            response      <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            state      <= IDLE;
            response   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            start_calc <= start_req;
            case (req_addr)
              ADDR_SCRATCH: scratch <= req_data;
              ADDR_PIXDATA: pix_ptr <= pix_ptr + 11'd1;
              ADDR_WGTDATA: wgt_ptr <= wgt_ptr + 11'd1;
              ADDR_PIXPTR:  pix_ptr <= req_data[10:0];
              ADDR_WGTPTR:  wgt_ptr <= req_data[10:0];
              default: ;
            endcase
          end
        end

        RDATA: begin
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          waitrequest <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_avalon_slave.sv
// Randomized bench for nn_avalon_slave: bus-level master tasks drive transfers and
// a transaction-level register/memory model supplies every expected value.
module tb_nn_avalon_slave;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        beginbursttransfer = 1'b0;
  logic [9:0]  burstcount = '0;
  logic [10:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic [1:0]  response;
  logic [16:0] result_output = '0;
  logic        done_calc = 1'b0;
  logic        start_calc;
  logic [3:0]  output_address;
  logic [10:0] pixel_address;
  logic [10:0] weight_address;
  logic        w_enable_pixels;
  logic        w_enable_weights;
  logic [15:0] store_data;

  nn_avalon_slave #(.NUM_RESULTS(10)) dut (
    .clk(clk), .n_rst(n_rst), .read(read), .write(write),
    .beginbursttransfer(beginbursttransfer), .burstcount(burstcount),
    .address(address), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest), .response(response),
    .result_output(result_output), .done_calc(done_calc), .start_calc(start_calc),
    .output_address(output_address), .pixel_address(pixel_address),
    .weight_address(weight_address), .w_enable_pixels(w_enable_pixels),
    .w_enable_weights(w_enable_weights), .store_data(store_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_low_cnt = 0;
  int start_cnt = 0;
  logic [27:0] obs_q[$];
  logic [27:0] exp_q[$];

  // Reference model state
  logic [31:0] m_scratch = '0;
  logic [10:0] m_pix = '0;
  logic [10:0] m_wgt = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_starts = 0;

  always @(negedge clk) begin
    if (!waitrequest) wr_low_cnt++;
    if (start_calc) start_cnt++;
    if (w_enable_pixels)  obs_q.push_back({1'b0, pixel_address, store_data});
    if (w_enable_weights) obs_q.push_back({1'b1, weight_address, store_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_scratch = '0;
    m_pix = '0;
    m_wgt = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void m_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b00;
    if (a == 11'd0)      d = {30'b0, m_busy, m_done};
    else if (a == 11'd1) d = m_scratch;
    else if (a == 11'd4) d = {21'b0, m_pix};
    else if (a == 11'd5) d = {21'b0, m_wgt};
    else if (a >= 11'd16 && a < 11'd26) d = {15'b0, result_output};
    else r = 2'b10;
  endfunction

  function automatic void m_write(input logic [10:0] a, input logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    case (a)
      11'd0: if (d[0] && !m_busy) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        m_starts++;
      end
      11'd1: m_scratch = d;
      11'd2: begin exp_q.push_back({1'b0, m_pix, d[15:0]}); m_pix = m_pix + 11'd1; end
      11'd3: begin exp_q.push_back({1'b1, m_wgt, d[15:0]}); m_wgt = m_wgt + 11'd1; end
      11'd4: m_pix = d[10:0];
      11'd5: m_wgt = d[10:0];
      default: r = 2'b10;
    endcase
  endfunction

  task automatic cmp_stores();
    logic [27:0] o, e;
    check_eq("store_count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_eq("store_entry", 32'(o), 32'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic bus_write(input logic [10:0] a, input logic [31:0] d, input logic bb,
                           input logic [9:0] bc, output logic [1:0] r);
    int wl0;
    bit got;
    wl0 = wr_low_cnt;
    got = 1'b0;
    address = a; writedata = d; beginbursttransfer = bb; burstcount = bc; write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (!waitrequest) begin got = 1'b1; break; end
    end
    check_eq("wr_accepted", 32'(got), 32'd1);
    @(posedge clk); #1;
    write = 1'b0; beginbursttransfer = 1'b0;
    r = response;
    check_eq("wr_waitreq_low_cycles", 32'(wr_low_cnt - wl0), 32'd1);
  endtask

  task automatic bus_read(input logic [10:0] a, input logic bb, input logic [9:0] bc,
                          output logic [31:0] d, output logic [1:0] r);
    int wl0, lat;
    bit got, acc;
    wl0 = wr_low_cnt;
    got = 1'b0; acc = 1'b0; lat = 0; d = '0; r = '0;
    address = a; beginbursttransfer = bb; burstcount = bc; read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (acc) begin read = 1'b0; beginbursttransfer = 1'b0; end
      if (!waitrequest) acc = 1'b1;
      if (readdatavalid) begin got = 1'b1; lat = i + 1; d = readdata; r = response; break; end
    end
    read = 1'b0; beginbursttransfer = 1'b0;
    check_eq("rd_valid_seen", 32'(got), 32'd1);
    check_eq("rd_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    check_eq("rdv_one_cycle", 32'(readdatavalid), 32'd0);
    check_eq("rd_waitreq_low_cycles", 32'(wr_low_cnt - wl0), 32'd1);
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d);
    logic [1:0] r, er;
    int s0;
    bus_write(a, d, 1'b0, 10'd0, r);
    s0 = m_starts;
    m_write(a, d, er);
    check_eq("wr_resp", 32'(r), 32'(er));
    if (a == 11'd0) check_eq("start_pulse", 32'(start_calc), 32'(m_starts - s0));
    cmp_stores();
  endtask

  task automatic do_read(input logic [10:0] a, output logic [31:0] d);
    logic [31:0] ed;
    logic [1:0] r, er;
    bus_read(a, 1'b0, 10'd0, d, r);
    m_read(a, ed, er);
    check_eq("rd_data", d, ed);
    check_eq("rd_resp", 32'(r), 32'(er));
    check_eq("out_addr", 32'(output_address), 32'(a[3:0]));
  endtask

  task automatic burst_write(input logic [10:0] a, input logic [9:0] bc, input bit seq);
    logic [1:0] r, er;
    logic [31:0] d;
    int beats;
    beats = (bc == 10'd0) ? 1 : int'(bc);
    for (int i = 0; i < beats; i++) begin
      d = seq ? 32'(2 * i) : $urandom;
      bus_write((i == 0) ? a : 11'($urandom), d, (i == 0), bc, r);
      m_write(a, d, er);
      check_eq("bwr_resp", 32'(r), 32'(er));
      cmp_stores();
    end
  endtask

  task automatic burst_read(input logic [10:0] a, input logic [9:0] bc);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    for (int i = 0; i < int'(bc); i++) begin
      bus_read((i == 0) ? a : 11'($urandom), (i == 0), bc, d, r);
      m_read(a, ed, er);
      check_eq("brd_data", d, ed);
      check_eq("brd_resp", 32'(r), 32'(er));
      check_eq("brd_out_addr", 32'(output_address), 32'(a[3:0]));
    end
  endtask

  task automatic pulse_done();
    done_calc = 1'b1;
    @(posedge clk); #1;
    done_calc = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b1;
  endtask

  function automatic logic [10:0] pick_mapped();
    return ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 5)) : 11'($urandom_range(16, 25));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int s0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_waitrequest", 32'(waitrequest), 32'd1);
    check_eq("rst_readdatavalid", 32'(readdatavalid), 32'd0);
    check_eq("rst_start_calc", 32'(start_calc), 32'd0);
    check_eq("rst_response", 32'(response), 32'd0);
    check_eq("rst_wen", 32'({w_enable_pixels, w_enable_weights}), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    do_write(11'h001, 32'h0000_0008);
    do_read(11'h001, d);
    check_eq("scratch_is_8", d, 32'h8);

    do_write(11'h004, 32'd5);
    burst_write(11'h002, 10'd10, 1'b1);
    do_read(11'h004, d);
    check_eq("pixptr_after_burst", d, 32'd15);

    s0 = start_cnt;
    do_write(11'h000, 32'd1);
    @(posedge clk); #1;
    check_eq("single_start_pulse", 32'(start_cnt - s0), 32'd1);
    do_read(11'h000, d);
    check_eq("ctrl_busy", d, 32'h2);
    do_write(11'h000, 32'd1);
    pulse_done();
    do_read(11'h000, d);
    check_eq("ctrl_done", d, 32'h1);

    result_output = 17'h1ABCD;
    do_read(11'h013, d);
    check_eq("result_read", d, 32'h0001_ABCD);
    check_eq("result_index", 32'(output_address), 32'd3);

    do_read(11'h002, d);
    check_eq("pixdata_rd_slverr", 32'(response), 32'h2);
    do_read(11'h7FF, d);
    check_eq("unmapped_rd_zero", d, 32'h0);
    do_write(11'h015, 32'h1234);
    do_write(11'h005, 32'd2047);
    do_write(11'h003, 32'h0000_BEEF);
    do_read(11'h005, d);
    check_eq("wgtptr_wrap", d, 32'd0);

    burst_write(11'h001, 10'd0, 1'b0);
    do_write(11'h004, 32'd7);
    do_read(11'h004, d);
    check_eq("single_after_burst0", d, 32'd7);
    burst_read(11'h001, 10'd3);

    // Abort a write mid-ACCEPT with the asynchronous reset
    do_write(11'h001, 32'h0000_1234);
    address = 11'h001; writedata = 32'hDEAD_BEEF; write = 1'b1;
    @(posedge clk); #1;
    check_eq("ar_in_accept", 32'(waitrequest), 32'd0);
    #1 n_rst = 1'b0;
    #1;
    check_eq("ar_waitrequest", 32'(waitrequest), 32'd1);
    check_eq("ar_response", 32'(response), 32'd0);
    write = 1'b0;
    #1 n_rst = 1'b1;
    m_reset();
    obs_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    do_read(11'h001, d);
    check_eq("ar_scratch_cleared", d, 32'd0);

    for (int it = 0; it < 150; it++) begin
      result_output = 17'($urandom);
      case ($urandom_range(0, 9))
        0: do_write(11'h001, $urandom);
        1: do_write(11'($urandom_range(4, 5)), $urandom);
        2: do_write(11'($urandom_range(2, 3)), $urandom);
        3: do_read(pick_mapped(), d);
        4: do_read(11'($urandom), d);
        5: do_write(11'($urandom), $urandom);
        6: burst_write(11'($urandom_range(2, 3)), 10'($urandom_range(0, 8)), 1'b0);
        7: burst_read(pick_mapped(), 10'($urandom_range(1, 4)));
        8: do_write(11'h000, $urandom);
        default: if (m_busy) pulse_done();
      endcase
    end

    @(posedge clk); #1;
    check_eq("start_total", 32'(start_cnt), 32'(m_starts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
